// File: rtl/cpu_mem_bus_arbiter.sv
// cpu_mem_bus_arbiter: shares the memory bus between the icache (fills only)
// and the dcache (fills and writebacks). One transaction in flight at a time,
// round-robin arbitration, response routing back to the owner, and a response
// watchdog that completes a hung transaction with an error.
module cpu_mem_bus_arbiter #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned LINE_WIDTH     = 128,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clock,
  input  logic                  reset,
  // icache
  input  logic                  i_req_valid,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  output logic                  i_available,
  output logic                  i_resp_valid,
  output logic [LINE_WIDTH-1:0] i_resp_data,
  output logic                  i_resp_error,
  // dcache
  input  logic                  d_req_valid,
  input  logic                  d_req_write,
  input  logic [ADDR_WIDTH-1:0] d_req_addr,
  input  logic [LINE_WIDTH-1:0] d_req_data,
  output logic                  d_available,
  output logic                  d_resp_valid,
  output logic [LINE_WIDTH-1:0] d_resp_data,
  output logic                  d_resp_error,
  // memory
  output logic                  mem_req_valid,
  output logic                  mem_req_write,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  output logic [LINE_WIDTH-1:0] mem_req_data,
  input  logic                  mem_available,
  input  logic                  mem_resp_valid,
  input  logic [LINE_WIDTH-1:0] mem_resp_data,
  // owner {d,i}
  output logic [1:0]            grant
);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;

  localparam int unsigned WD_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  state_t                state_q, state_d;
  logic [1:0]            grant_q, grant_d;
  logic                  ptr_q, ptr_d;      // 0: icache wins ties, 1: dcache wins ties
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LINE_WIDTH-1:0] data_q, data_d;
  logic                  write_q, write_d;
  logic [WD_W-1:0]       wdog_q, wdog_d;
  logic                  i_rv_q, i_rv_d;
  logic                  d_rv_q, d_rv_d;
  logic                  i_err_q, i_err_d;
  logic                  d_err_q, d_err_d;
  logic [LINE_WIDTH-1:0] rdata_q, rdata_d;

  logic idle;
  logic i_acc;
  logic d_acc;
  logic timeout_hit;

  assign idle        = (state_q == ST_IDLE);
  assign i_available = idle & mem_available & ~(d_req_valid & ptr_q);
  assign d_available = idle & mem_available & ~(i_req_valid & ~ptr_q);
  assign i_acc       = i_req_valid & i_available;
  assign d_acc       = d_req_valid & d_available;
  // Fires on the last waiting cycle so the error pulse lands exactly
  // TIMEOUT_CYCLES cycles after entering WAIT.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && ((32'(wdog_q) + 32'd1) == TIMEOUT_CYCLES);

  // State and datapath registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      ptr_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      write_q <= 1'b0;
      wdog_q  <= '0;
      i_rv_q  <= 1'b0;
      d_rv_q  <= 1'b0;
      i_err_q <= 1'b0;
      d_err_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      write_q <= write_d;
      wdog_q  <= wdog_d;
      i_rv_q  <= i_rv_d;
      d_rv_q  <= d_rv_d;
      i_err_q <= i_err_d;
      d_err_q <= d_err_d;
      rdata_q <= rdata_d;
    end
  end

  // Next-state logic for the bus FSM
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (i_acc || d_acc) state_d = ST_ISSUE;
      ST_ISSUE: if (mem_available) state_d = ST_WAIT;
      ST_WAIT:  if (mem_resp_valid || timeout_hit) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Request capture, response routing and watchdog updates
  always_comb begin
    grant_d = grant_q;
    ptr_d   = ptr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    write_d = write_q;
    wdog_d  = wdog_q;
    rdata_d = rdata_q;
    i_rv_d  = 1'b0;
    d_rv_d  = 1'b0;
    i_err_d = 1'b0;
    d_err_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        wdog_d = '0;
        if (i_acc) begin
          grant_d = 2'b01;
          ptr_d   = 1'b1;
          addr_d  = i_req_addr;
          data_d  = '0;
          write_d = 1'b0;
        end else if (d_acc) begin
          grant_d = 2'b10;
          ptr_d   = 1'b0;
          addr_d  = d_req_addr;
          data_d  = d_req_data;
          write_d = d_req_write;
        end
      end
      ST_WAIT: begin
        wdog_d = wdog_q + WD_W'(1);
        if (mem_resp_valid) begin
          i_rv_d  = grant_q[0];
          d_rv_d  = grant_q[1];
          rdata_d = mem_resp_data;
          grant_d = '0;
          wdog_d  = '0;
        end else if (timeout_hit) begin
          i_rv_d  = grant_q[0];
          d_rv_d  = grant_q[1];
          i_err_d = grant_q[0];
          d_err_d = grant_q[1];
          rdata_d = '0;
          grant_d = '0;
          wdog_d  = '0;
        end
      end
      default: ;
    endcase
  end

  // Output decode from registered state
  always_comb begin
    mem_req_valid = (state_q == ST_ISSUE);
    mem_req_write = write_q;
    mem_req_addr  = addr_q;
    mem_req_data  = data_q;
    grant         = grant_q;
    i_resp_valid  = i_rv_q;
    d_resp_valid  = d_rv_q;
    i_resp_error  = i_err_q;
    d_resp_error  = d_err_q;
    i_resp_data   = rdata_q;
    d_resp_data   = rdata_q;
  end

endmodule

// File: tb/tb_cpu_mem_bus_arbiter.sv
// Scoreboard bench for cpu_mem_bus_arbiter: directed stimulus pushes expected
// memory requests and responses; a monitor pops and compares them.
module tb_cpu_mem_bus_arbiter;

  localparam int AW = 32;
  localparam int LW = 128;

  logic          clock;
  logic          reset;
  logic          i_req_valid;
  logic [AW-1:0] i_req_addr;
  logic          i_available;
  logic          i_resp_valid;
  logic [LW-1:0] i_resp_data;
  logic          i_resp_error;
  logic          d_req_valid;
  logic          d_req_write;
  logic [AW-1:0] d_req_addr;
  logic [LW-1:0] d_req_data;
  logic          d_available;
  logic          d_resp_valid;
  logic [LW-1:0] d_resp_data;
  logic          d_resp_error;
  logic          mem_req_valid;
  logic          mem_req_write;
  logic [AW-1:0] mem_req_addr;
  logic [LW-1:0] mem_req_data;
  logic          mem_available;
  logic          mem_resp_valid;
  logic [LW-1:0] mem_resp_data;
  logic [1:0]    grant;

  cpu_mem_bus_arbiter #(
    .ADDR_WIDTH(AW),
    .LINE_WIDTH(LW),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clock(clock), .reset(reset),
    .i_req_valid(i_req_valid), .i_req_addr(i_req_addr), .i_available(i_available),
    .i_resp_valid(i_resp_valid), .i_resp_data(i_resp_data), .i_resp_error(i_resp_error),
    .d_req_valid(d_req_valid), .d_req_write(d_req_write), .d_req_addr(d_req_addr),
    .d_req_data(d_req_data), .d_available(d_available), .d_resp_valid(d_resp_valid),
    .d_resp_data(d_resp_data), .d_resp_error(d_resp_error),
    .mem_req_valid(mem_req_valid), .mem_req_write(mem_req_write), .mem_req_addr(mem_req_addr),
    .mem_req_data(mem_req_data), .mem_available(mem_available), .mem_resp_valid(mem_resp_valid),
    .mem_resp_data(mem_resp_data), .grant(grant)
  );

  typedef struct {
    logic          is_d;
    logic          wr;
    logic [LW-1:0] data;
    logic          err;
  } resp_t;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [LW-1:0] data;
  } mreq_t;

  resp_t exp_resp[$];
  mreq_t exp_mreq[$];

  int vectors     = 0;
  int miscompares = 0;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got running required finished");
    $fatal(1, "bench time limit");
  end

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    i_req_valid    = 1'b0;
    i_req_addr     = '0;
    d_req_valid    = 1'b0;
    d_req_write    = 1'b0;
    d_req_addr     = '0;
    d_req_data     = '0;
    mem_available  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    cyc();
    cyc();
    exp_resp.delete();
    exp_mreq.delete();
    reset = 1'b0;
  endtask

  task automatic respond(input logic [LW-1:0] data);
    mem_resp_valid = 1'b1;
    mem_resp_data  = data;
    cyc();
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
  endtask

  task automatic push_mreq(input logic wr, input logic [AW-1:0] a, input logic [LW-1:0] d);
    mreq_t m;
    m.wr = wr; m.addr = a; m.data = d;
    exp_mreq.push_back(m);
  endtask

  task automatic push_resp(input logic is_d, input logic wr, input logic [LW-1:0] d, input logic err);
    resp_t r;
    r.is_d = is_d; r.wr = wr; r.data = d; r.err = err;
    exp_resp.push_back(r);
  endtask

  // Monitor: checks every memory handshake and every cache response
  always @(negedge clock) begin
    if (!reset) begin
      if (mem_req_valid && mem_available) begin
        if (exp_mreq.size() == 0) begin
          chk("mem_req_unexpected", LW'(mem_req_valid), '0);
        end else begin
          mreq_t m;
          m = exp_mreq.pop_front();
          chk("mem_req_write", LW'(mem_req_write), LW'(m.wr));
          chk("mem_req_addr", LW'(mem_req_addr), LW'(m.addr));
          if (m.wr) chk("mem_req_data", mem_req_data, m.data);
        end
      end
      if (i_resp_valid || d_resp_valid) begin
        if (exp_resp.size() == 0) begin
          chk("resp_unexpected", LW'({d_resp_valid, i_resp_valid}), '0);
        end else begin
          resp_t r;
          r = exp_resp.pop_front();
          chk("resp_master", LW'({d_resp_valid, i_resp_valid}), r.is_d ? LW'(2'b10) : LW'(2'b01));
          chk("resp_error", LW'(r.is_d ? d_resp_error : i_resp_error), LW'(r.err));
          if (!r.wr) chk("resp_data", r.is_d ? d_resp_data : i_resp_data, r.data);
        end
      end
    end
  end

  logic [LW-1:0] D1, D2, D3, D4, D5, D55;

  initial begin
    D1  = {4{32'hDEADBEEF}};
    D2  = {4{32'h11112222}};
    D3  = {4{32'hA5A5C3C3}};
    D4  = {4{32'h0BADF00D}};
    D5  = {4{32'hFEEDFACE}};
    D55 = {16{8'h55}};

    // Test 1: reset state, single icache fill
    do_reset();
    chk("rst_grant", LW'(grant), '0);
    chk("rst_i_resp_valid", LW'(i_resp_valid), '0);
    chk("rst_d_resp_valid", LW'(d_resp_valid), '0);
    chk("rst_resp_error", LW'({i_resp_error, d_resp_error}), '0);
    chk("rst_mem_req_valid", LW'(mem_req_valid), '0);
    chk("rst_mem_req_addr", LW'(mem_req_addr), '0);
    chk("rst_i_resp_data", i_resp_data, '0);
    i_req_valid   = 1'b1;
    i_req_addr    = 32'h1000;
    mem_available = 1'b1;
    #1;
    chk("t1_i_available", LW'(i_available), LW'(1));
    push_mreq(1'b0, 32'h1000, '0);
    push_resp(1'b0, 1'b0, D1, 1'b0);
    cyc();
    i_req_valid = 1'b0;
    chk("t1_mem_req_valid", LW'(mem_req_valid), LW'(1));
    chk("t1_grant_issue", LW'(grant), LW'(2'b01));
    cyc();
    chk("t1_mem_req_valid_wait", LW'(mem_req_valid), '0);
    chk("t1_grant_wait", LW'(grant), LW'(2'b01));
    cyc();
    cyc();
    respond(D1);
    chk("t1_i_resp_valid", LW'(i_resp_valid), LW'(1));
    chk("t1_i_resp_data", i_resp_data, D1);
    chk("t1_grant_done", LW'(grant), '0);
    cyc();
    chk("t1_i_resp_pulse", LW'(i_resp_valid), '0);

    // Test 2: simultaneous requests, round robin
    do_reset();
    i_req_valid   = 1'b1;
    i_req_addr    = 32'h3000;
    d_req_valid   = 1'b1;
    d_req_write   = 1'b0;
    d_req_addr    = 32'h4000;
    mem_available = 1'b1;
    #1;
    chk("t2_i_available", LW'(i_available), LW'(1));
    chk("t2_d_available", LW'(d_available), '0);
    push_mreq(1'b0, 32'h3000, '0);
    push_resp(1'b0, 1'b0, D2, 1'b0);
    cyc();
    i_req_valid = 1'b0;
    chk("t2_grant_i", LW'(grant), LW'(2'b01));
    chk("t2_d_blocked_busy", LW'(d_available), '0);
    cyc();
    respond(D2);
    i_req_valid = 1'b1;
    #1;
    chk("t2_i_resp_valid", LW'(i_resp_valid), LW'(1));
    chk("t2_d_available_rr", LW'(d_available), LW'(1));
    chk("t2_i_available_rr", LW'(i_available), '0);
    push_mreq(1'b0, 32'h4000, '0);
    push_resp(1'b1, 1'b0, D3, 1'b0);
    cyc();
    i_req_valid = 1'b0;
    d_req_valid = 1'b0;
    chk("t2_grant_d", LW'(grant), LW'(2'b10));
    cyc();
    respond(D3);
    chk("t2_d_resp_valid", LW'(d_resp_valid), LW'(1));
    chk("t2_grant_done", LW'(grant), '0);
    cyc();

    // Test 3: dcache writeback with memory back-pressure in ISSUE
    d_req_valid = 1'b1;
    d_req_write = 1'b1;
    d_req_addr  = 32'h2040;
    d_req_data  = D55;
    #1;
    chk("t3_d_available", LW'(d_available), LW'(1));
    push_mreq(1'b1, 32'h2040, D55);
    push_resp(1'b1, 1'b1, '0, 1'b0);
    cyc();
    d_req_valid   = 1'b0;
    d_req_write   = 1'b0;
    d_req_data    = '0;
    mem_available = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("t3_hold_valid", LW'(mem_req_valid), LW'(1));
      chk("t3_hold_addr", LW'(mem_req_addr), LW'(32'h2040));
      chk("t3_hold_data", mem_req_data, D55);
      chk("t3_hold_write", LW'(mem_req_write), LW'(1));
      cyc();
    end
    mem_available = 1'b1;
    chk("t3_issue_5th", LW'(mem_req_valid), LW'(1));
    cyc();
    chk("t3_wait_no_req", LW'(mem_req_valid), '0);
    respond(D5);
    chk("t3_d_resp_valid", LW'(d_resp_valid), LW'(1));
    chk("t3_d_resp_error", LW'(d_resp_error), '0);
    cyc();

    // Test 4: watchdog expiry, then normal service
    i_req_valid = 1'b1;
    i_req_addr  = 32'h5000;
    push_mreq(1'b0, 32'h5000, '0);
    push_resp(1'b0, 1'b0, '0, 1'b1);
    cyc();
    i_req_valid = 1'b0;
    cyc();
    for (int k = 0; k < 8; k++) begin
      chk("t4_wdog_early", LW'(i_resp_valid), '0);
      cyc();
    end
    chk("t4_timeout_valid", LW'(i_resp_valid), LW'(1));
    chk("t4_timeout_error", LW'(i_resp_error), LW'(1));
    chk("t4_timeout_data", i_resp_data, '0);
    chk("t4_grant_idle", LW'(grant), '0);
    d_req_valid = 1'b1;
    d_req_write = 1'b0;
    d_req_addr  = 32'h6000;
    #1;
    chk("t4_d_available", LW'(d_available), LW'(1));
    push_mreq(1'b0, 32'h6000, '0);
    push_resp(1'b1, 1'b0, D4, 1'b0);
    cyc();
    d_req_valid = 1'b0;
    cyc();
    respond(D4);
    chk("t4_d_resp_valid", LW'(d_resp_valid), LW'(1));
    chk("t4_d_resp_error", LW'(d_resp_error), '0);
    cyc();

    // Test 5: reset during WAIT, then a stray response
    i_req_valid = 1'b1;
    i_req_addr  = 32'h7000;
    push_mreq(1'b0, 32'h7000, '0);
    push_resp(1'b0, 1'b0, D5, 1'b0);
    cyc();
    i_req_valid = 1'b0;
    cyc();
    cyc();
    reset = 1'b1;
    exp_resp.delete();
    cyc();
    reset = 1'b0;
    chk("t5_grant_after_rst", LW'(grant), '0);
    chk("t5_mem_req_after_rst", LW'(mem_req_valid), '0);
    mem_resp_valid = 1'b1;
    mem_resp_data  = D5;
    cyc();
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    chk("t5_stray_i", LW'(i_resp_valid), '0);
    chk("t5_stray_d", LW'(d_resp_valid), '0);
    chk("t5_stray_grant", LW'(grant), '0);
    cyc();
    chk("t5_stray_late", LW'({i_resp_valid, d_resp_valid}), '0);

    // Test 6: memory unavailable in IDLE blocks both masters
    mem_available = 1'b0;
    i_req_valid   = 1'b1;
    i_req_addr    = 32'h8000;
    d_req_valid   = 1'b1;
    d_req_addr    = 32'h9000;
    #1;
    chk("t6_i_available", LW'(i_available), '0);
    chk("t6_d_available", LW'(d_available), '0);
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("t6_no_req", LW'(mem_req_valid), '0);
      chk("t6_no_grant", LW'(grant), '0);
    end
    i_req_valid   = 1'b0;
    d_req_valid   = 1'b0;
    mem_available = 1'b1;
    cyc();
    cyc();

    chk("end_resp_pending", LW'(exp_resp.size()), '0);
    chk("end_mreq_pending", LW'(exp_mreq.size()), '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cpu_mem_bus_arbiter.md
Name: cpu_mem_bus_arbiter

Overview:
- Shares the single physical memory bus between the instruction cache (fetch stage, read-only) and the data cache (reads and writebacks).
- Owns the bus FSM. Captures one request at a time and drives it to memory, then routes the response back to the originating cache.
- Generates each cache's per-master bus-available signal using round-robin arbitration, plus a response watchdog.

Parameters:
ADDR_WIDTH, 32, physical address width.
LINE_WIDTH, 128, cache line width carried on the memory bus.
TIMEOUT_CYCLES, 255, maximum cycles waiting for a memory response before an error completion; 0 disables the watchdog.

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  reset, synchronous, active-high.
i_req_valid  in  1  icache line-fill request.
i_req_addr  in  ADDR_WIDTH  icache fill address (line aligned).
i_available  out  1  icache may issue this cycle.
i_resp_valid  out  1  one-cycle pulse: fill data valid.
i_resp_data  out  LINE_WIDTH  fill data.
i_resp_error  out  1  qualifies i_resp_valid: watchdog expiry.
d_req_valid  in  1  dcache request.
d_req_write  in  1  1 = writeback, 0 = fill.
d_req_addr  in  ADDR_WIDTH  dcache address.
d_req_data  in  LINE_WIDTH  writeback data.
d_available, d_resp_valid, d_resp_data, d_resp_error  out  1/1/LINE_WIDTH/1  as icache equivalents.
mem_req_valid  out  1  request to memory.
mem_req_write  out  1  write flag.
mem_req_addr  out  ADDR_WIDTH  address.
mem_req_data  out  LINE_WIDTH  write data.
mem_available  in  1  memory can accept a request this cycle.
mem_resp_valid  in  1  memory response/ack pulse.
mem_resp_data  in  LINE_WIDTH  read data (ignored for writes).
grant  out  2  one-hot owner {d,i}; 00 when idle.

Behaviour:
- **FSM states:** IDLE, ISSUE, WAIT.
- **Reset:** state=IDLE, grant=00, all *_valid, *_error and mem_req_* outputs 0, data outputs 0, round-robin pointer favours icache, watchdog=0. Reset mid-operation abandons the transaction; a later mem_resp_valid arriving in IDLE is ignored.
- **Availability:** i_available = (state==IDLE) & mem_available & ~(d_req_valid & ptr==D). d_available is symmetric. With no contention, the sole requester is always available.
- **Acceptance:** a request is accepted when x_req_valid & x_available in IDLE. Only one master can be accepted per cycle.
  - Round robin: the pointer flips to the other master after every acceptance.
  - Accepted addr/data/write are registered (icache write forced 0).
  - grant is set and state becomes ISSUE.
- **ISSUE:** mem_req_valid=1 with the registered fields. The handshake completes when mem_available=1; then go to WAIT. Otherwise hold all fields stable.
- **WAIT:** mem_req_valid=0 and the watchdog counts up.
  - On mem_resp_valid, the next cycle drives the granted master's resp_valid=1 with registered mem_resp_data (error=0). Go to IDLE, grant=00, watchdog=0.
  - For writes, the ack also pulses d_resp_valid; d_resp_data is don't-care.
- **Watchdog:** if TIMEOUT_CYCLES≠0 and the counter reaches TIMEOUT_CYCLES with no response, pulse the granted master's resp_valid and resp_error, resp_data=0, then go to IDLE.
- **Same-cycle response and timeout:** the response wins.
- **Latency:** accept at cycle N; mem_req_valid at N+1 (earliest accept by memory). A response at M gives resp_valid at M+1, and a new acceptance is also possible at M+1.
- **Non-granted master:** resp_valid stays 0 throughout.
- **Simultaneous requests:** the pointer decides; the loser waits and wins the next arbitration if still requesting (no starvation).

Test Plan:
1. Reset then i_req_valid=1, addr=0x1000, mem_available=1; memory responds 3 cycles after issue with 0xDEADBEEF… → mem_req_valid at cycle 1, i_resp_valid one cycle after mem_resp_valid with that data, grant=01 then 00.
2. Both request in the same cycle after reset → icache granted first (i_available=1, d_available=0). After its completion, dcache is granted even though icache re-requests.
3. d writeback addr=0x2040, data=0x55…; mem_available held 0 for 4 cycles in ISSUE → mem_req fields stable 4 cycles, accepted on 5th; ack gives d_resp_valid=1, d_resp_error=0.
4. TIMEOUT_CYCLES=8, memory never responds → i_resp_valid=1, i_resp_error=1 exactly 8 cycles after entering WAIT; FSM returns to IDLE and a following request is served normally.
5. Reset asserted during WAIT, then stray mem_resp_valid → no resp_valid on either master, grant=00.
6. mem_available=0 in IDLE with pending requests → both available signals 0, no acceptance, no mem_req_valid.
